// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O hub: register offsets
// relative to IO_BASE, register-select encoding and counter sizing.
package board_io_pkg;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_KEY_STATE,
        SEL_KEY_EVENT,
        SEL_IRQ_MASK
    } reg_sel_e;

    function automatic int ofs_key_state(input int num_out);
        return num_out;
    endfunction

    function automatic int ofs_key_event(input int num_out);
        return num_out + 1;
    endfunction

    function automatic int ofs_irq_mask(input int num_out);
        return num_out + 2;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, polarity normalisation, stability
// counter, debounced pressed level and a one-cycle press-accepted pulse.
module key_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic pressed,
    output logic rise
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_PIN = (ACTIVE_LOW != 0);

    logic          sync1_q;
    logic          sync2_q;
    logic          sample;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sample  = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign pressed = stable_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sample;
            cnt_d    = '0;
            rise     = sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser powers up at the released pin level so reset never looks like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_PIN;
            sync2_q  <= IDLE_PIN;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/board_io_hub.sv
// Board I/O and reset block between the AVR data bus and board pins.
// Optional key-event interrupt and IRQ_MASK register: define BOARD_IO_IRQ_EN.
module board_io_hub
    import board_io_pkg::*;
#(
    parameter logic [15:0] IO_BASE         = 16'h0020,
    parameter int          NUM_OUT         = 4,
    parameter int          NUM_KEYS        = 2,
    parameter int          KEY_ACTIVE_LOW  = 1,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          RESET_HOLD      = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 locked,
    output logic                 core_reset_n,
    input  logic [15:0]          address,
    input  logic [7:0]           wdata,
    input  logic                 we,
    output logic [7:0]           rdata,
    output logic                 hit,
    input  logic [NUM_KEYS-1:0]  keys,
    output logic [8*NUM_OUT-1:0] out_port,
    output logic                 irq
);

    localparam logic [15:0] OFS_KS = 16'(ofs_key_state(NUM_OUT));
    localparam logic [15:0] OFS_KE = 16'(ofs_key_event(NUM_OUT));
`ifdef BOARD_IO_IRQ_EN
    localparam logic [15:0] OFS_IM   = 16'(ofs_irq_mask(NUM_OUT));
    localparam logic [15:0] WIN_SIZE = OFS_IM + 16'd1;
`else
    localparam logic [15:0] WIN_SIZE = OFS_KE + 16'd1;
`endif
    localparam int            HW        = cnt_width(RESET_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam int            OW        = cnt_width(NUM_OUT);

    genvar gi;

    // ---------------- reset sequencer ----------------
    logic          lock_meta_q;
    logic          lock_sync_q;
    logic [HW-1:0] hold_cnt_q;
    logic [HW-1:0] hold_cnt_d;
    logic          core_rst_n_q;
    logic          core_rst_n_d;

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        core_rst_n_d = core_rst_n_q;
        if (!lock_sync_q) begin
            hold_cnt_d   = '0;
            core_rst_n_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
            core_rst_n_d = 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            lock_meta_q  <= locked;
            lock_sync_q  <= lock_meta_q;
            hold_cnt_q   <= hold_cnt_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign core_reset_n = core_rst_n_q;

    // ---------------- address decode ----------------
    logic [15:0] offset;
    reg_sel_e    sel;
    logic        wr;

    // Addresses below IO_BASE wrap to large offsets and fall outside the window.
    assign offset = address - IO_BASE;
    assign hit    = (offset < WIN_SIZE);
    assign wr     = we & hit;

    always_comb begin
        sel = SEL_NONE;
        if (offset < 16'(NUM_OUT))
            sel = SEL_OUT;
        else if (offset == OFS_KS)
            sel = SEL_KEY_STATE;
        else if (offset == OFS_KE)
            sel = SEL_KEY_EVENT;
`ifdef BOARD_IO_IRQ_EN
        else if (offset == OFS_IM)
            sel = SEL_IRQ_MASK;
`endif
    end

    // ---------------- output registers ----------------
    logic [7:0] out_rd [NUM_OUT];

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            logic [7:0] reg_q;
            logic [7:0] reg_d;

            assign reg_d = (wr && sel == SEL_OUT && offset[OW-1:0] == OW'(gi)) ? wdata : reg_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    reg_q <= 8'h00;
                else
                    reg_q <= reg_d;
            end

            assign out_rd[gi]           = reg_q;
            assign out_port[8*gi +: 8] = reg_q;
        end
    endgenerate

    // ---------------- keys and event latch ----------------
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_rise;
    logic [NUM_KEYS-1:0] evt_clr;
    logic [NUM_KEYS-1:0] event_q;
    logic [NUM_KEYS-1:0] event_d;

    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (KEY_ACTIVE_LOW)
            ) u_key (
                .clock   (clock),
                .reset_n (reset_n),
                .key     (keys[gi]),
                .pressed (key_state[gi]),
                .rise    (key_rise[gi])
            );
        end
    endgenerate

    // A press accepted in the same cycle as a clear keeps its bit set.
    assign evt_clr = (wr && sel == SEL_KEY_EVENT) ? wdata[NUM_KEYS-1:0] : '0;
    assign event_d = (event_q & ~evt_clr) | key_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            event_q <= '0;
        else
            event_q <= event_d;
    end

    // ---------------- interrupt ----------------
`ifdef BOARD_IO_IRQ_EN
    logic [NUM_KEYS-1:0] mask_q;
    logic [NUM_KEYS-1:0] mask_d;
    logic                irq_q;

    assign mask_d = (wr && sel == SEL_IRQ_MASK) ? wdata[NUM_KEYS-1:0] : mask_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(event_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        rdata = 8'h00;
        case (sel)
            SEL_OUT:       rdata = out_rd[offset[OW-1:0]];
            SEL_KEY_STATE: rdata[NUM_KEYS-1:0] = key_state;
            SEL_KEY_EVENT: rdata[NUM_KEYS-1:0] = event_q;
`ifdef BOARD_IO_IRQ_EN
            SEL_IRQ_MASK:  rdata[NUM_KEYS-1:0] = mask_q;
`endif
            default:       rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_board_io_hub.sv
// Directed bench for board_io_hub with a behavioural reference model and a
// per-cycle compare; define BOARD_IO_IRQ_EN to also exercise the interrupt.
module tb_board_io_hub;

    localparam int NK   = 2;
    localparam int NO   = 4;
    localparam int DC   = 4;
    localparam int RH   = 8;
    localparam int BASE = 32'h20;
`ifdef BOARD_IO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam int WIN = IRQ_EN ? NO + 3 : NO + 2;

    logic          clock;
    logic          reset_n;
    logic          locked;
    logic          core_reset_n;
    logic [15:0]   address;
    logic [7:0]    wdata;
    logic          we;
    logic [7:0]    rdata;
    logic          hit;
    logic [NK-1:0] keys;
    logic [8*NO-1:0] out_port;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    board_io_hub #(
        .IO_BASE         (16'h0020),
        .NUM_OUT         (NO),
        .NUM_KEYS        (NK),
        .KEY_ACTIVE_LOW  (1),
        .DEBOUNCE_CYCLES (DC),
        .RESET_HOLD      (RH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .locked       (locked),
        .core_reset_n (core_reset_n),
        .address      (address),
        .wdata        (wdata),
        .we           (we),
        .rdata        (rdata),
        .hit          (hit),
        .keys         (keys),
        .out_port     (out_port),
        .irq          (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic          m_lh1, m_lh2;      // locked pin as seen 1 and 2 edges ago
    int            m_run;             // consecutive edges with synced lock high
    logic [NK-1:0] m_kh1, m_kh2;      // key pins as seen 1 and 2 edges ago
    logic [NK-1:0] m_stable;
    int            m_mis [NK];        // consecutive edges the pressed sample disagreed
    logic [7:0]    m_out [NO];
    logic [NK-1:0] m_event;
    logic [7:0]    m_mask;
    logic          m_irq;

    function automatic int moff(input logic [15:0] a);
        return int'({16'h0000, a}) - BASE;
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        return (moff(a) >= 0) && (moff(a) < WIN);
    endfunction

    function automatic logic [7:0] m_rdata(input logic [15:0] a);
        int o;
        o = moff(a);
        if (o < 0 || o >= WIN) return 8'h00;
        if (o < NO)            return m_out[o];
        if (o == NO)           return {6'b0, m_stable};
        if (o == NO + 1)       return {6'b0, m_event};
        return m_mask;
    endfunction

    function automatic logic [8*NO-1:0] m_outs();
        logic [8*NO-1:0] v;
        for (int k = 0; k < NO; k++) v[8*k +: 8] = m_out[k];
        return v;
    endfunction

    // Keys whose press is accepted at the coming edge (pins are active low).
    function automatic logic [NK-1:0] m_press();
        logic [NK-1:0] r;
        r = '0;
        for (int k = 0; k < NK; k++)
            if (!m_kh2[k] && !m_stable[k] && m_mis[k] + 1 >= DC) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [NK-1:0] m_clr();
        if (we && m_hit(address) && moff(address) == NO + 1) return wdata[NK-1:0];
        return '0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_lh1    <= 1'b0;
            m_lh2    <= 1'b0;
            m_run    <= 0;
            m_kh1    <= '1;
            m_kh2    <= '1;
            m_stable <= '0;
            for (int k = 0; k < NK; k++) m_mis[k] <= 0;
            for (int k = 0; k < NO; k++) m_out[k] <= 8'h00;
            m_event  <= '0;
            m_mask   <= 8'h00;
            m_irq    <= 1'b0;
        end else begin
            m_lh1 <= locked;
            m_lh2 <= m_lh1;
            m_run <= m_lh2 ? m_run + 1 : 0;
            m_kh1 <= keys;
            m_kh2 <= m_kh1;
            for (int k = 0; k < NK; k++) begin
                if (!m_kh2[k] == m_stable[k]) begin
                    m_mis[k] <= 0;
                end else if (m_mis[k] + 1 >= DC) begin
                    m_stable[k] <= !m_kh2[k];
                    m_mis[k]    <= 0;
                end else begin
                    m_mis[k] <= m_mis[k] + 1;
                end
            end
            if (we && m_hit(address) && moff(address) < NO) m_out[moff(address)] <= wdata;
            if (IRQ_EN && we && m_hit(address) && moff(address) == NO + 2) m_mask <= wdata & 8'h03;
            m_event <= (m_event & ~m_clr()) | m_press();
            m_irq   <= IRQ_EN && ((m_event & m_mask[NK-1:0]) != '0);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("cyc_core_reset_n", 32'(core_reset_n), 32'(m_run >= RH));
        check("cyc_out_port", 32'(out_port), 32'(m_outs()));
        check("cyc_hit", 32'(hit), 32'(m_hit(address)));
        check("cyc_rdata", 32'(rdata), 32'(m_rdata(address)));
        check("cyc_irq", 32'(irq), 32'(m_irq));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        address = a;
        wdata   = d;
        we      = 1'b1;
        tick();
        we      = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(name, 32'(rdata), 32'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 1'b0;
        locked  = 1'b0;
        keys    = 2'b11;
        address = 16'h0000;
        wdata   = 8'h00;
        we      = 1'b0;
        repeat (3) tick();
        check("rst_core_reset_n", 32'(core_reset_n), 32'h0);
        check("rst_out_port", 32'(out_port), 32'h0);

        // lock rises at cycle 0, core released on the 10th edge
        reset_n = 1'b1;
        locked  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("lock_rise", 32'(core_reset_n), 32'(c >= 10));
        end
        repeat (3) tick();

        // one-cycle lock loss
        locked = 1'b0;
        tick();
        locked = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("lock_drop", 32'(core_reset_n), 32'((c == 1) || (c == 10)));
        end

        // output register write and out-of-window write
        bus_write(16'h0022, 8'hA5);
        check("out2_port", 32'(out_port[23:16]), 32'hA5);
        check("out2_rdata", 32'(rdata), 32'hA5);
        check("out2_hit", 32'(hit), 32'h1);
        bus_write(16'h0030, 8'h5A);
        check("oow_hit", 32'(hit), 32'h0);
        check("oow_out_port", 32'(out_port), 32'h00A5_0000);
        address = 16'h001F;
        #1;
        check("below_base_hit", 32'(hit), 32'h0);

        // key 0 held low: accepted on the 6th edge
        address = 16'h0024;
        keys    = 2'b10;
        repeat (5) tick();
        check("ks_after5", 32'(rdata), 32'h00);
        tick();
        check("ks_after6", 32'(rdata), 32'h01);
        read_chk("ke_after6", 16'h0025, 8'h01);

        // two-cycle glitch on key 1 is rejected
        keys = 2'b00;
        repeat (2) tick();
        keys = 2'b10;
        repeat (8) tick();
        read_chk("ks_glitch", 16'h0024, 8'h01);
        read_chk("ke_glitch", 16'h0025, 8'h01);

        // release key 0: no event, state drops
        keys = 2'b11;
        repeat (8) tick();
        read_chk("ks_release", 16'h0024, 8'h00);
        read_chk("ke_release", 16'h0025, 8'h01);

        // W1C on the same edge a new press is accepted: set wins
        keys = 2'b10;
        repeat (5) tick();
        bus_write(16'h0025, 8'h01);
        check("w1c_race", 32'(rdata), 32'h01);
        bus_write(16'h0025, 8'h01);
        check("w1c_clear", 32'(rdata), 32'h00);
        bus_write(16'h0024, 8'h00);
        check("ks_write_ignored", 32'(rdata), 32'h01);

`ifdef BOARD_IO_IRQ_EN
        bus_write(16'h0026, 8'h02);
        check("mask_rd", 32'(rdata), 32'h02);
        check("irq_idle", 32'(irq), 32'h0);
        keys = 2'b00;
        repeat (6) tick();
        check("irq_same_edge", 32'(irq), 32'h0);
        read_chk("ke_key1", 16'h0025, 8'h02);
        tick();
        check("irq_set", 32'(irq), 32'h1);
        bus_write(16'h0025, 8'h02);
        check("irq_lag", 32'(irq), 32'h1);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
        keys = 2'b01;
        repeat (8) tick();
        keys = 2'b00;
        repeat (8) tick();
        check("irq_masked", 32'(irq), 32'h0);
        read_chk("ke_key0_masked", 16'h0025, 8'h01);
`else
        address = 16'h0026;
        #1;
        check("mask_ofs_hit", 32'(hit), 32'h0);
        check("mask_ofs_rdata", 32'(rdata), 32'h00);
        check("irq_tied", 32'(irq), 32'h0);
`endif

        // asynchronous reset mid-debounce with OUT0 set
        keys = 2'b11;
        bus_write(16'h0020, 8'hFF);
        check("out0_ff", 32'(out_port[7:0]), 32'hFF);
        repeat (8) tick();
        keys = 2'b10;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_port", 32'(out_port), 32'h0);
        check("arst_core", 32'(core_reset_n), 32'h0);
        keys = 2'b11;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        read_chk("arst_ke", 16'h0025, 8'h00);
        read_chk("arst_ks", 16'h0024, 8'h00);
        repeat (4) tick();
        check("arst_core_back", 32'(core_reset_n), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/board_io_hub.md
Name: board_io_hub

Overview:
- Parametrised board I/O and reset block placed between the AVR core data bus and the board pins (LEDs, keys) in each board top.
- Holds the core in reset until the PLL lock has been stable for a set time.
- Provides NUM_OUT memory-mapped 8-bit output registers.
- Debounces NUM_KEYS push-buttons and latches their press events.
- Returns read data plus a hit flag so the top can mux it against RAM.

Parameters:
- IO_BASE, 16'h0020, data-space address of register offset 0.
- NUM_OUT, 4, number of 8-bit output registers (1..16).
- NUM_KEYS, 2, number of key inputs (1..8).
- KEY_ACTIVE_LOW, 1, 1 = pin low means pressed.
- DEBOUNCE_CYCLES, 250000, stable cycles required before a key change is accepted (>=2).
- RESET_HOLD, 1024, cycles lock must stay high before core reset is released (>=1).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- locked  in  1  PLL lock, asynchronous to logic; synchronised internally.
- core_reset_n  out  1  reset to core, active-low, registered.
- address  in  16  core data address.
- wdata  in  8  core write data.
- we  in  1  core write strobe, one cycle per write.
- rdata  out  8  read data, combinational from address.
- hit  out  1  address in the I/O window, combinational.
- keys  in  NUM_KEYS  raw button pins, asynchronous.
- out_port  out  8*NUM_OUT  register k drives bits [8k+7:8k].
- irq  out  1  event interrupt; exists only with BOARD_IO_IRQ_EN, tied 0 otherwise.

Behaviour:
- Reset state (reset_n=0, asynchronous): core_reset_n=0, out_port=0, event latch=0, irq=0, mask=0, debounce counters=0. Key stable state = released (pressed bit 0). Synchroniser flops reset to the released pin level.
- Reset sequencer:
  - locked passes through a 2-flop synchroniser.
  - Hold counter counts while synced lock=1.
  - core_reset_n rises on the cycle the counter reaches RESET_HOLD-1 and stays high.
  - Synced lock=0 at any time clears the counter and drives core_reset_n=0 on the next edge.
  - Total latency from locked rising = 2 sync cycles + RESET_HOLD cycles.
- Address map (offset = address - IO_BASE):
  - 0..NUM_OUT-1: OUT[k], R/W.
  - NUM_OUT: KEY_STATE, R/O; bit i = debounced pressed; unused bits read 0.
  - NUM_OUT+1: KEY_EVENT, read; write-1-to-clear.
  - NUM_OUT+2: IRQ_MASK, R/W (feature only).
  - hit=1 when offset is in range, computed as an unsigned 16-bit compare.
  - Reads of unmapped offsets inside the window return 0. With the feature off, window size = NUM_OUT+2.
- Writes take effect on the edge where we=1 and hit=1. we with hit=0 is ignored. Writes to KEY_STATE are ignored.
- Debounce, per key:
  - 2-flop sync, then normalise polarity so 1 = pressed.
  - If sampled value equals stable value, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the stable value takes the sample and the counter clears.
  - Counter width = $clog2(DEBOUNCE_CYCLES).
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Event latch: stable transition 0->1 sets KEY_EVENT[i] on the same edge the stable value updates.
- Simultaneous set and W1C on the same bit in the same cycle: set wins.
- Releases do not set events.
- core_reset_n does not reset this block; the registers survive a lock loss.

Optional Feature:
- Macro BOARD_IO_IRQ_EN.
- Defined:
  - IRQ_MASK register exists at offset NUM_OUT+2.
  - irq is registered: irq <= |(KEY_EVENT & IRQ_MASK), 1-cycle latency.
  - irq stays high until the events are cleared or masked.
- Undefined: no mask register, irq tied 0, and offset NUM_OUT+2 is outside the window (hit=0).

Decomposition:
- Package board_io_pkg holds the offset constants: OFS_KEY_STATE = NUM_OUT, OFS_KEY_EVENT = NUM_OUT+1, OFS_IRQ_MASK = NUM_OUT+2, each expressed as functions of NUM_OUT.
- The package also holds a helper function for counter width.
- One sub-module, key_debounce: sync + counter + stable output + rise pulse for one key, instantiated NUM_KEYS times with generate.

Test Plan (DEBOUNCE_CYCLES=4, RESET_HOLD=8, IO_BASE=16'h0020, NUM_OUT=4, NUM_KEYS=2, KEY_ACTIVE_LOW=1):
- Lock sequence: reset_n released, locked=1 at cycle 0 -> core_reset_n rises at cycle 10 exactly. Drop locked for 1 cycle -> core_reset_n low 2-3 cycles later, then high again 10 cycles after locked returns.
- Output write: write 8'hA5 to 16'h0022 -> out_port[23:16]=8'hA5 next edge and rdata=8'hA5 with hit=1. Write to 16'h0030 -> no change, hit=0.
- Debounce: keys[0]=0 held 6 cycles -> KEY_STATE (16'h0024) reads 8'h01 and KEY_EVENT (16'h0025) reads 8'h01. A 2-cycle low pulse on keys[1] -> both stay 0 for bit 1.
- W1C race: write 8'h01 to 16'h0025 on the same cycle a new key-0 press is accepted -> bit 0 remains 1. A later write 8'h01 with no new press -> reads 0.
- IRQ (BOARD_IO_IRQ_EN): write 8'h02 to 16'h0026, press key 1 -> irq=1 one cycle after the event sets. Clear the event -> irq=0. Press key 0 with mask 8'h02 -> irq stays 0.
- Async reset mid-operation: assert reset_n=0 while OUT[0]=8'hFF and a debounce count is in progress -> out_port=0, core_reset_n=0 immediately with no clock edge. After release, no spurious event is latched.
